// File: rtl/cic_pkg.sv
// Shared defaults for the CIC capture path: sample width, channel count, FIFO depth,
// and the FIFO entry layout (tag in the upper bits, sample in the lower bits).
package cic_pkg;

    localparam int CIC_DATA_W     = 32;
    localparam int CIC_NUM_CH     = 4;
    localparam int CIC_FIFO_DEPTH = 16;

    typedef logic [$clog2(CIC_NUM_CH)-1:0] ch_tag_t;

    // Entry packing order is {tag, data}; parameterised users build the same layout by concatenation.
    typedef struct packed {
        ch_tag_t                tag;
        logic [CIC_DATA_W-1:0]  data;
    } entry_t;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cic_capture_arbiter_if.sv
// Channel inputs, tagged output stream and status bundle of the capture arbiter.
// slave is the arbiter side, master is the side that feeds samples and drains the stream.
interface cic_capture_arbiter_if
    import cic_pkg::*;
#(
    parameter int NUM_CH     = CIC_NUM_CH,
    parameter int DATA_W     = CIC_DATA_W,
    parameter int FIFO_DEPTH = CIC_FIFO_DEPTH
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int LVL_W = level_width(FIFO_DEPTH);

    logic                     capture_en;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     out_ready;
    logic [LVL_W-1:0]         fifo_level;
    logic [NUM_CH-1:0]        overrun;
    logic                     clear_ovr;

    modport slave (
        input  capture_en, ch_data, ch_valid, out_ready, clear_ovr,
        output out_data, out_ch, out_valid, fifo_level, overrun
    );

    modport master (
        output capture_en, ch_data, ch_valid, out_ready, clear_ovr,
        input  out_data, out_ch, out_valid, fifo_level, overrun
    );

endinterface

// File: rtl/cic_sample_fifo.sv
// First-word-fall-through FIFO for tagged samples; the head is visible whenever valid_o is high.
// full_o and level_o are registered and change the cycle after a push or pop.
module cic_sample_fifo
    import cic_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = CIC_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_data_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          head_o,
    output logic                      valid_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    level_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
        full_d = (level_d == LVL_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (level_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign full_o  = full_q;
    assign level_o = level_q;

endmodule

// File: rtl/cic_capture_arbiter.sv
// Per-channel hold registers, round-robin grant into a shared FWFT FIFO, and sticky overrun flags.
// One sample per clock can be granted into the FIFO and one drained from it.
module cic_capture_arbiter
    import cic_pkg::*;
#(
    parameter int NUM_CH     = CIC_NUM_CH,
    parameter int DATA_W     = CIC_DATA_W,
    parameter int FIFO_DEPTH = CIC_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    cic_capture_arbiter_if.slave  bus
);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int ENTRY_W = CH_W + DATA_W;

    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] ovr_set;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [DATA_W-1:0] hold_q [NUM_CH];
    logic [DATA_W-1:0] hold_d [NUM_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic              fifo_full;
    logic              fifo_valid;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    int                cand;

    // Round-robin search from ptr; the registered full flag suppresses every grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!grant_any && !fifo_full && pend_q[CH_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    // A capture coinciding with its own grant re-arms pend instead of counting as a loss.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign capture[gi]   = bus.ch_valid[gi] && bus.capture_en;
        assign grant[gi]     = grant_any && (grant_idx == CH_W'(gi));
        assign ovr_set[gi]   = capture[gi] && pend_q[gi] && !grant[gi];
        assign pend_d[gi]    = capture[gi] || (pend_q[gi] && !grant[gi]);
        assign overrun_d[gi] = ovr_set[gi] || (overrun_q[gi] && !bus.clear_ovr);
        assign hold_d[gi]    = capture[gi] ? bus.ch_data[gi*DATA_W +: DATA_W] : hold_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            overrun_q <= '0;
            ptr_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            ptr_q     <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            hold_q[k] <= rst ? '0 : hold_d[k];
        end
    end

    // The granted entry carries the sample held before this cycle's capture.
    assign push_entry = {grant_idx, hold_q[grant_idx]};

    cic_sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (grant_any),
        .push_data_i (push_entry),
        .pop_i       (bus.out_ready && fifo_valid),
        .head_o      (head_entry),
        .valid_o     (fifo_valid),
        .full_o      (fifo_full),
        .level_o     (bus.fifo_level)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_ch    = head_entry[ENTRY_W-1 -: CH_W];
    assign bus.out_data  = head_entry[DATA_W-1:0];
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_cic_capture_arbiter.sv
// Randomised and directed stimulus against a queue-based reference model; a separate
// monitor pops expected entries whenever the DUT hands one over.
module tb_cic_capture_arbiter;
    import cic_pkg::*;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int CH_W       = 2;
    localparam int ENTRY_W    = CH_W + DATA_W;
    localparam int DW_ALL     = NUM_CH * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    cic_capture_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    cic_capture_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state as seen by the outputs during the current cycle.
    int                 m_level = 0;
    int                 m_ptr   = 0;
    bit [NUM_CH-1:0]    m_pend  = '0;
    bit [NUM_CH-1:0]    m_ovr   = '0;
    bit                 m_fresh = 1'b1;
    logic [DATA_W-1:0]  m_hold [NUM_CH];
    logic [ENTRY_W-1:0] exp_q [$];

    bit                 chk_en    = 1'b0;
    bit                 exp_valid = 1'b0;
    int                 exp_level = 0;
    bit [NUM_CH-1:0]    exp_ovr   = '0;
    bit                 exp_fresh = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW_ALL-1:0] rnd_data();
        logic [DW_ALL-1:0] d;
        for (int k = 0; k < NUM_CH; k++) d[k*DATA_W +: DATA_W] = $urandom;
        return d;
    endfunction

    // Applies one cycle of stimulus and advances the model to what the next cycle should show.
    task automatic drive(input logic cap_en, input logic [NUM_CH-1:0] vld,
                         input logic [DW_ALL-1:0] data, input logic ordy,
                         input logic clr, input logic r);
        int  g;
        bit  pop;
        bit  cap;
        @(posedge clk);
        #1;
        exp_valid = (m_level != 0);
        exp_level = m_level;
        exp_ovr   = m_ovr;
        exp_fresh = m_fresh;
        rst            = r;
        bus.capture_en = cap_en;
        bus.ch_valid   = vld;
        bus.ch_data    = data;
        bus.out_ready  = r ? 1'b0 : ordy;
        bus.clear_ovr  = clr;
        if (r) begin
            m_level = 0; m_ptr = 0; m_pend = '0; m_ovr = '0; m_fresh = 1'b1;
            exp_q.delete();
        end else begin
            g   = -1;
            pop = (m_level > 0) && ordy;
            if (m_level < FIFO_DEPTH) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    int k = (m_ptr + i) % NUM_CH;
                    if (g < 0 && m_pend[k]) g = k;
                end
            end
            if (g >= 0) begin
                exp_q.push_back({CH_W'(g), m_hold[g]});
                m_ptr   = (g + 1) % NUM_CH;
                m_fresh = 1'b0;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                cap = vld[k] && cap_en;
                if (cap && m_pend[k] && k != g) m_ovr[k] = 1'b1;
                else if (clr) m_ovr[k] = 1'b0;
                if (cap) begin
                    m_hold[k] = data[k*DATA_W +: DATA_W];
                    m_pend[k] = 1'b1;
                end else if (k == g) begin
                    m_pend[k] = 1'b0;
                end
            end
            m_level = m_level + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive(1'b1, '0, rnd_data(), ordy, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [ENTRY_W-1:0] e;
        if (chk_en) begin
            check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
            check("fifo_level", 64'(bus.fifo_level), 64'(exp_level));
            check("overrun", 64'(bus.overrun), 64'(exp_ovr));
            if (exp_fresh) begin
                check("reset_out_data", 64'(bus.out_data), 64'd0);
                check("reset_out_ch", 64'(bus.out_ch), 64'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=ch%0d/%08h required=no entry at %0t",
                             bus.out_ch, bus.out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_ch", 64'(bus.out_ch), 64'(e[ENTRY_W-1 -: CH_W]));
                    check("out_data", 64'(bus.out_data), 64'(e[DATA_W-1:0]));
                    $display("POP ch=%0d data=%08h expected ch=%0d data=%08h",
                             bus.out_ch, bus.out_data, e[ENTRY_W-1 -: CH_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        logic [DW_ALL-1:0] d;
        bus.capture_en = 1'b0;
        bus.ch_valid   = '0;
        bus.ch_data    = '0;
        bus.out_ready  = 1'b0;
        bus.clear_ovr  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) m_hold[k] = '0;

        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Single sample on channel 2
        d = '0;
        d[2*DATA_W +: DATA_W] = 32'h0000_1234;
        drive(1'b1, 4'b0100, d, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Simultaneous bursts, second one starting from ptr = 1
        drive(1'b1, 4'hF, rnd_data(), 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1);
        drive(1'b1, 4'b0001, rnd_data(), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        drive(1'b1, 4'hF, rnd_data(), 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1);

        // Fill to saturation with the consumer stalled, then force overruns and drain
        for (int i = 0; i < 17; i++) drive(1'b1, NUM_CH'(1 << (i % NUM_CH)), rnd_data(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'hF, rnd_data(), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(26, 1'b1);
        drive(1'b1, '0, rnd_data(), 1'b1, 1'b1, 1'b0);

        // Capture on channel 1 in the same cycle as its grant
        drive(1'b1, 4'b0010, rnd_data(), 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'b0010, rnd_data(), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Overrun on channel 3 coinciding with clear_ovr, then a lone clear
        drive(1'b1, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) drive(1'b1, 4'b0001, rnd_data(), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, rnd_data(), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, rnd_data(), 1'b0, 1'b1, 1'b0);
        drive(1'b1, '0, rnd_data(), 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(24, 1'b1);

        // capture_en low ignores pulses
        for (int i = 0; i < 3; i++) drive(1'b0, 4'hF, rnd_data(), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Reset with five entries queued
        drive(1'b1, 4'hF, rnd_data(), 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        drive(1'b1, 4'b0001, rnd_data(), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        drive(1'b1, '0, rnd_data(), 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Random traffic with phases of consumer back-pressure
        for (int i = 0; i < 800; i++) begin
            logic ordy;
            ordy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 7) != 0, NUM_CH'($urandom), rnd_data(), ordy,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        end
        idle(40, 1'b1);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_capture_arbiter.md
# cic_capture_arbiter

Collects decimated samples from NUM_CH parallel CIC filter instances, one per microphone, and serialises them into one channel-tagged stream for the MicroBlaze peripheral interface. Each channel has a single-entry hold register. A round-robin arbiter moves held samples into a shared FIFO, which the bus side drains through a valid/ready handshake. The block also reports per-channel overrun and the FIFO fill level.

## Interface
- NUM_CH, 4, number of CIC channels (2..8)
- DATA_W, 32, sample width; matches CIC data_out
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥4
- CH_W, $clog2(NUM_CH), channel tag width (derived)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset; one clock, synchronous, active-high
- capture_en  in  1  when low, new ch_valid pulses are ignored
- ch_data  in  NUM_CH*DATA_W  channel k in bits [k*DATA_W +: DATA_W]
- ch_valid  in  NUM_CH  one-cycle pulse per channel, aligned with ch_data
- out_data  out  DATA_W  FIFO head sample
- out_ch  out  CH_W  channel tag of the head sample
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer accepts the head when out_valid && out_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overrun  out  NUM_CH  sticky per-channel sample-loss flags
- clear_ovr  in  1  clears all overrun bits

## Operation
Hold registers:
- ch_valid[k] && capture_en latches ch_data slice k into hold[k] and sets pend[k].
- If pend[k] is still set and not granted in that cycle, the new sample overwrites the old one and overrun[k] is set.
- If the capture and the grant of channel k happen in the same cycle, the new sample is latched, pend[k] stays 1, and no overrun is flagged.

Arbiter:
- Grants only when the FIFO is not full, using the registered full flag. At most one grant per cycle.
- Round-robin search starts at ptr: the lowest channel ≥ ptr with pend set, wrapping to channel 0.
- After a grant to channel k, ptr = (k+1) mod NUM_CH. With no grant, ptr holds.
- The grant pushes {k, hold[k]} into the FIFO and clears pend[k], unless the same-cycle capture rule above applies.
- When the FIFO is full, pend bits hold and further captures on a pending channel overrun.

FIFO:
- First-word-fall-through: out_data and out_ch show the head whenever out_valid = 1.
- A pop occurs on out_valid && out_ready.
- Push and pop in the same cycle leave fifo_level unchanged.
- out_ready while empty has no effect.

Overrun:
- Set has priority over clear_ovr in the same cycle.
- capture_en low does not flush pend; held samples still drain.

## Timing
- Reset values: pend = 0, ptr = 0, FIFO empty, out_valid = 0, out_data = 0, out_ch = 0, fifo_level = 0, overrun = 0.
- Reset mid-operation discards all held and queued samples. No output pulse occurs during reset.
- Latency: ch_valid at cycle t → pend at t+1 → FIFO write at the end of t+1 → out_valid at t+2 (empty FIFO, no contention).
- Worst-case wait for a pending channel is NUM_CH−1 grant cycles.
- fifo_level and full update in the cycle after a push or pop.
- The full flag blocks grants from the cycle after the FIFO reaches FIFO_DEPTH.
- Throughput: one sample per clock in and one sample per clock out.

## Structure
- Shared package cic_pkg holds the CIC DATA_W default, the channel tag type, the FIFO_DEPTH default and the entry packing order {tag, data}.
- Sub-module cic_sample_fifo: a synchronous first-word-fall-through FIFO of width CH_W+DATA_W. It exposes push, pop, head, valid, full and level.
- Arbiter, hold registers and overrun logic stay in the top level.

## Test plan
- Single channel: after reset, ch_valid[2] pulse with data 0x00001234 at t, out_ready = 1 → out_valid at t+2 with out_data = 0x00001234 and out_ch = 2, then fifo_level returns to 0.
- Simultaneous pulses on all 4 channels, out_ready = 1 → output order ch0, ch1, ch2, ch3. Next simultaneous burst after ptr = 1 gives ch1, ch2, ch3, ch0.
- out_ready = 0, 17 pulses spread over channels → fifo_level saturates at 16. Pulses on pending channels set the matching overrun bit. After raising out_ready the 16 queued entries drain in FIFO order with their tags.
- Capture of ch1 in the same cycle as its grant → two ch1 samples are delivered and overrun[1] stays 0.
- clear_ovr asserted in the same cycle as a new overrun on ch3 → overrun[3] = 1. The next clear_ovr alone → overrun = 0.
- capture_en = 0 with ch_valid pulses → no output. rst asserted with 5 entries queued → the next cycle shows out_valid = 0 and fifo_level = 0.
